// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard enables, branch redirect, instruction memory port, IF/ID outputs.
interface fetch_stage_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic              le_pc;
    logic              le_npc;
    logic              le_ifid;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
    logic [XLEN-1:0]   imem_instr;
    logic [XLEN-1:0]   imem_addr;
    logic [XLEN-1:0]   ifid_instr;
    logic [XLEN-1:0]   ifid_pc;
    logic              ifid_valid;
    logic [CNT_W-1:0]  stall_count;

    // Environment side: drives enables, branch redirect and the memory read data.
    modport master (
        output le_pc, le_npc, le_ifid, branch_taken, branch_target, imem_instr,
        input  imem_addr, ifid_instr, ifid_pc, ifid_valid, stall_count
    );

    // Fetch stage side.
    modport slave (
        input  le_pc, le_npc, le_ifid, branch_taken, branch_target, imem_instr,
        output imem_addr, ifid_instr, ifid_pc, ifid_valid, stall_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with delayed-branch PC/NPC pair and IF/ID register.
// Optional stall-cycle counter enabled by defining FETCH_STALL_COUNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic            ifid_valid;
    logic            ifid_load_c;
    logic            ifid_clear_c;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: FILL lasts one edge, RUN is terminal until reset.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = FILL;
        endcase
    end

    // FSM outputs: FILL invalidates IF/ID, RUN follows the hazard enable.
    always_comb begin
        ifid_load_c  = 1'b0;
        ifid_clear_c = 1'b0;
        case (state)
            FILL:    ifid_clear_c = 1'b1;
            RUN:     ifid_load_c  = bus.le_ifid;
            default: ifid_clear_c = 1'b1;
        endcase
    end

    // PC takes NPC; NPC takes the branch target or steps by 4 (wraps mod 2^32).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            npc <= RESET_PC + PC_STEP;
        end else begin
            if (bus.le_pc) begin
                pc <= npc;
            end
            if (bus.le_npc) begin
                npc <= bus.branch_taken ? bus.branch_target : npc + PC_STEP;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (ifid_clear_c) begin
            ifid_valid <= 1'b0;
        end else if (ifid_load_c) begin
            ifid_instr <= bus.imem_instr;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.ifid_instr = ifid_instr;
    assign bus.ifid_pc    = ifid_pc;
    assign bus.ifid_valid = ifid_valid;

`ifdef FETCH_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_count;
    logic             stall_inc_c;

    assign stall_inc_c = (state == RUN) && !bus.le_ifid;

    // Saturating count of RUN cycles in which IF/ID was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_inc_c && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign bus.stall_count = stall_count;
`else
    assign bus.stall_count = '0;
`endif

endmodule
